cpu_bus1_master: RTL

// - CPU-side master for the CPU<->Cache bus (A1/D1/C1). Sits directly upstream of Cache.
// - Converts one-cycle parallel requests (cmd, 19-bit addr, 32-bit wdata) into bus-1 transfers:
//   the command goes out with the first address half, the second half follows.
// - Hands bus ownership to the cache and collects C1_RESPONSE plus read data.
// - Returns a single-cycle response to the requester.

---
 rtl/cpu_bus1_master_pkg.sv | 47 ++++
 rtl/cpu_bus1_master_tristate_drv.sv | 13 +
 rtl/cpu_bus1_master.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bus1_master_pkg.sv
// Bus-1 (CPU<->Cache) shared definitions: bus widths, C1 command codes, master FSM states.
// Also holds the read-data masking rule applied when the first D1 beat is captured.
package cpu_bus1_master_pkg;

    localparam int ADDR1_BUS_SIZE = 15;
    localparam int OFFSET_SIZE    = 4;
    localparam int DATA1_BUS_SIZE = 16;
    localparam int CTR1_BUS_SIZE  = 3;
    localparam int REQ_ADDR_SIZE  = ADDR1_BUS_SIZE + OFFSET_SIZE;
    localparam int REQ_DATA_SIZE  = 2 * DATA1_BUS_SIZE;

    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RECV2 = 3'd4,
        ST_RESP  = 3'd5
    } bus1_mst_state_t;

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    // Writes and invalidates return zero, so their response beat is discarded here.
    function automatic logic [REQ_DATA_SIZE-1:0] rd_lo_capture(
        input logic [CTR1_BUS_SIZE-1:0]  cmd,
        input logic [DATA1_BUS_SIZE-1:0] d
    );
        case (cmd)
            C1_READ8:             return {24'd0, d[7:0]};
            C1_READ16, C1_READ32: return {16'd0, d};
            default:              return '0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus1_master_tristate_drv.sv
// Tri-state line driver for one bus-1 signal group: drives val_i when en_i, else releases to 'z.
// Purely combinational; no latency, no flow control.
module bus1_tristate_drv #(
    parameter int WIDTH = 1
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] val_i,
    inout  wire  [WIDTH-1:0] bus_io
);

    assign bus_io = en_i ? val_i : {WIDTH{1'bz}};

endmodule

// File: rtl/cpu_bus1_master.sv
// CPU-side bus-1 master: one parallel request -> two-cycle A1/C1(/D1) send, wait for C1_RESPONSE, one-cycle rsp.
// Latency 3+k cycles from acceptance (k = WAIT cycles, +1 for READ32); NOP completes next cycle.
// Backpressure: req_ready only in IDLE, one transaction outstanding. BUS1_TIMEOUT_EN adds a WAIT watchdog.
module cpu_bus1_master
    import cpu_bus1_master_pkg::*;
`ifdef BUS1_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CTR1_BUS_SIZE-1:0]  req_cmd,
    input  logic [REQ_ADDR_SIZE-1:0]  req_addr,
    input  logic [REQ_DATA_SIZE-1:0]  req_wdata,
    output logic                      rsp_valid,
    output logic [REQ_DATA_SIZE-1:0]  rsp_rdata,
    output logic                      rsp_err,
    inout  wire  [ADDR1_BUS_SIZE-1:0] A1,
    inout  wire  [DATA1_BUS_SIZE-1:0] D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]  C1
);

    bus1_mst_state_t            state_q, state_d;
    logic [CTR1_BUS_SIZE-1:0]   cmd_q;
    logic [REQ_ADDR_SIZE-1:0]   addr_q;
    logic [REQ_DATA_SIZE-1:0]   wdata_q;
    logic [REQ_DATA_SIZE-1:0]   rdata_q, rdata_d;
    logic                       accept;
    logic                       c1_rsp;

    assign accept = (state_q == ST_IDLE) && req_valid;
    // 'z/'x on C1 compares unknown and so falls through as "keep waiting".
    assign c1_rsp = (C1 == C1_RESPONSE);

`ifdef BUS1_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef BUS1_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (req_cmd == C1_NOP) ? ST_RESP : ST_SEND1;
                    rdata_d = '0;
`ifdef BUS1_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_SEND1: state_d = ST_SEND2;
            ST_SEND2: state_d = ST_WAIT;
            ST_WAIT: begin
                if (c1_rsp) begin
                    rdata_d = rd_lo_capture(cmd_q, D1);
                    state_d = (cmd_q == C1_READ32) ? ST_RECV2 : ST_RESP;
                end
`ifdef BUS1_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_RECV2: begin
                rdata_d[REQ_DATA_SIZE-1:DATA1_BUS_SIZE] = D1;
                state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_q   <= C1_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cmd_q   <= req_cmd;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef BUS1_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;

    // Lines are owned only during the two send cycles; bus is released everywhere else.
    logic                      send1, send2, own_bus, d1_en;
    logic [ADDR1_BUS_SIZE-1:0] a1_val;
    logic [DATA1_BUS_SIZE-1:0] d1_val;

    assign send1   = (state_q == ST_SEND1);
    assign send2   = (state_q == ST_SEND2);
    assign own_bus = send1 || send2;
    assign a1_val  = send1 ? addr_q[REQ_ADDR_SIZE-1:OFFSET_SIZE]
                           : {{(ADDR1_BUS_SIZE-OFFSET_SIZE){1'b0}}, addr_q[OFFSET_SIZE-1:0]};
    assign d1_en   = (send1 && is_write(cmd_q)) || (send2 && (cmd_q == C1_WRITE32));
    assign d1_val  = send1 ? wdata_q[DATA1_BUS_SIZE-1:0] : wdata_q[REQ_DATA_SIZE-1:DATA1_BUS_SIZE];

    bus1_tristate_drv #(.WIDTH(ADDR1_BUS_SIZE)) u_a1_drv (
        .en_i   (own_bus),
        .val_i  (a1_val),
        .bus_io (A1)
    );

    bus1_tristate_drv #(.WIDTH(DATA1_BUS_SIZE)) u_d1_drv (
        .en_i   (d1_en),
        .val_i  (d1_val),
        .bus_io (D1)
    );

    bus1_tristate_drv #(.WIDTH(CTR1_BUS_SIZE)) u_c1_drv (
        .en_i   (own_bus),
        .val_i  (cmd_q),
        .bus_io (C1)
    );

endmodule
